// File: rtl/feeder_pkg.sv
// Shared types and constants for the systolic array input feeder.
package feeder_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    STREAM    = 2'd1,
    WAIT_DONE = 2'd2
  } feeder_state_t;

  localparam int W_MAX_DEF  = 8;
  localparam int PREC_MIN   = 2;
  localparam int TILE_CNT_W = 16;

  // A precision is usable only if it fits the per-column weight field.
  function automatic logic prec_ok(logic [3:0] p, int w_max);
    return (int'(p) >= PREC_MIN) && (int'(p) <= w_max);
  endfunction

endpackage

// File: rtl/weight_serializer.sv
// N parallel right-shift registers that present each column weight LSB first.
module weight_serializer #(
  parameter int N     = 2,
  parameter int W_MAX = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               shift,
  input  logic [N*W_MAX-1:0] w_in,
  output logic [N-1:0]       w_bits
);

  for (genvar c = 0; c < N; c++) begin : g_col
    logic [W_MAX-1:0] sr;

    always_ff @(posedge clk) begin
      if (rst) begin
        sr <= '0;
      end else if (load) begin
        sr <= w_in[c*W_MAX +: W_MAX];
      end else if (shift) begin
        sr <= sr >> 1;
      end
    end

    assign w_bits[c] = sr[0];
  end

endmodule

// File: rtl/systolic_feeder.sv
// Double-buffered tile feeder: parallel activations plus bit-serial weights
// into the systolic array, then waits for the array's completion pulse.
module systolic_feeder
  import feeder_pkg::*;
#(
  parameter int ACT_WIDTH    = 16,
  parameter int N            = 2,
  parameter int W_MAX        = W_MAX_DEF,
  parameter int DONE_TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ld_valid,
  output logic                   ld_ready,
  input  logic [N*ACT_WIDTH-1:0] ld_act,
  input  logic [N*W_MAX-1:0]     ld_w,
  input  logic [3:0]             ld_prec,
  input  logic                   sa_done,
  output logic                   active,
  output logic [3:0]             precision,
  output logic [N*ACT_WIDTH-1:0] act_out,
  output logic [N-1:0]           w_out,
  output logic                   busy,
  output logic [TILE_CNT_W-1:0]  tile_cnt,
  output logic                   err,
  output logic [1:0]             state_dbg
);

  localparam int TO_W = $clog2(DONE_TIMEOUT + 1);

  // Load handshake: a tile transfers on ld_valid && ld_ready; ld_ready is high
  // exactly while the shadow buffer is empty and never depends on ld_valid.
  feeder_state_t          state;
  logic                   sh_full;
  logic [N*ACT_WIDTH-1:0] sh_act;
  logic [N*W_MAX-1:0]     sh_w;
  logic [3:0]             sh_prec;
  logic [3:0]             bit_cnt;
  logic [TO_W-1:0]        to_cnt;
  logic [N-1:0]           w_bits;
  logic                   load_fire;
  logic                   move;
  logic                   prec_good;

  assign ld_ready  = !sh_full;
  assign load_fire = ld_valid && ld_ready;
  assign move      = (state == IDLE) && sh_full;
  assign prec_good = prec_ok(ld_prec, W_MAX);
  assign busy      = (state != IDLE);
  assign state_dbg = state;
  assign w_out     = w_bits & {N{active}};

  weight_serializer #(.N(N), .W_MAX(W_MAX)) u_ser (
    .clk    (clk),
    .rst    (rst),
    .load   (move),
    .shift  (state == STREAM),
    .w_in   (sh_w),
    .w_bits (w_bits)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sh_full   <= 1'b0;
      sh_act    <= '0;
      sh_w      <= '0;
      sh_prec   <= '0;
      bit_cnt   <= '0;
      to_cnt    <= '0;
      active    <= 1'b0;
      precision <= '0;
      act_out   <= '0;
      tile_cnt  <= '0;
      err       <= 1'b0;
    end else begin
      // A new load wins over the move so the shadow keeps the incoming tile.
      if (load_fire) begin
        sh_full <= 1'b1;
        sh_act  <= ld_act;
        sh_w    <= ld_w;
        sh_prec <= prec_good ? ld_prec : 4'(W_MAX);
        if (!prec_good) err <= 1'b1;
      end else if (move) begin
        sh_full <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (sh_full) begin
            state     <= STREAM;
            active    <= 1'b1;
            act_out   <= sh_act;
            precision <= sh_prec;
            bit_cnt   <= '0;
          end
        end
        STREAM: begin
          if (bit_cnt == precision - 4'd1) begin
            state  <= WAIT_DONE;
            active <= 1'b0;
            to_cnt <= '0;
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
          end
        end
        WAIT_DONE: begin
          if (sa_done) begin
            state     <= IDLE;
            tile_cnt  <= tile_cnt + TILE_CNT_W'(1);
            act_out   <= '0;
            precision <= '0;
          end else if (to_cnt == TO_W'(DONE_TIMEOUT - 1)) begin
            state     <= IDLE;
            err       <= 1'b1;
            act_out   <= '0;
            precision <= '0;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder: tiles are scoreboarded at load
// time and each active burst is compared bit by bit against the stored tile.
module tb_systolic_feeder;

  localparam int ACT_WIDTH = 16;
  localparam int N         = 2;
  localparam int W_MAX     = 8;
  localparam int TW        = 4 + N*W_MAX + N*ACT_WIDTH;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   ld_valid;
  logic                   ld_ready;
  logic [N*ACT_WIDTH-1:0] ld_act;
  logic [N*W_MAX-1:0]     ld_w;
  logic [3:0]             ld_prec;
  logic                   sa_done;
  logic                   active;
  logic [3:0]             precision;
  logic [N*ACT_WIDTH-1:0] act_out;
  logic [N-1:0]           w_out;
  logic                   busy;
  logic [15:0]            tile_cnt;
  logic                   err;
  logic [1:0]             state_dbg;

  logic done_resp = 1'b0;
  logic done_stray = 1'b0;
  logic resp_en = 1'b1;
  assign sa_done = done_resp | done_stray;

  logic [TW-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int exp_tiles = 0;
  logic exp_err = 1'b0;

  systolic_feeder #(.ACT_WIDTH(ACT_WIDTH), .N(N), .W_MAX(W_MAX), .DONE_TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_act(ld_act),
    .ld_w(ld_w), .ld_prec(ld_prec), .sa_done(sa_done), .active(active),
    .precision(precision), .act_out(act_out), .w_out(w_out), .busy(busy),
    .tile_cnt(tile_cnt), .err(err), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] eff_prec(logic [3:0] p);
    return (p >= 4'd2 && p <= 4'(W_MAX)) ? p : 4'(W_MAX);
  endfunction

  function automatic logic [N-1:0] bits_at(logic [N*W_MAX-1:0] w, int k);
    logic [N-1:0] r;
    for (int c = 0; c < N; c++) r[c] = w[c*W_MAX + k];
    return r;
  endfunction

  // Burst monitor: every active burst must be the oldest loaded tile.
  logic [TW-1:0] cur;
  logic have_cur = 1'b0;
  logic in_burst = 1'b0;
  int k = 0;

  always @(negedge clk) begin
    if (rst) begin
      in_burst = 1'b0;
      have_cur = 1'b0;
    end else begin
      if (active) begin
        if (!in_burst) begin
          in_burst = 1'b1;
          k = 0;
          if (exp_q.size() == 0) check("unexpected_burst", 1, 0);
          else begin
            cur = exp_q.pop_front();
            have_cur = 1'b1;
          end
        end
        if (have_cur) begin
          check("act_out", act_out, cur[0 +: N*ACT_WIDTH]);
          check("precision", precision, cur[TW-1 -: 4]);
          if (k < int'(cur[TW-1 -: 4]))
            check("w_out", w_out, bits_at(cur[N*ACT_WIDTH +: N*W_MAX], k));
        end
        k++;
      end else begin
        if (in_burst) begin
          in_burst = 1'b0;
          if (have_cur) check("burst_len", k, cur[TW-1 -: 4]);
        end
        if (busy && have_cur) check("act_hold", act_out, cur[0 +: N*ACT_WIDTH]);
        if (!busy) begin
          have_cur = 1'b0;
          check("act_idle", act_out, 0);
        end
      end
    end
  end

  // Array model: answers each finished burst with one sa_done pulse.
  initial begin : responder
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) prev = 1'b0;
      else begin
        if (resp_en && prev && !active) begin
          repeat ($urandom_range(0, 4)) @(negedge clk);
          done_resp = 1'b1;
          exp_tiles++;
          @(negedge clk);
          done_resp = 1'b0;
        end
        prev = active;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ld_valid = 1'b0;
    done_stray = 1'b0;
    repeat (3) @(negedge clk);
    exp_q.delete();
    exp_tiles = 0;
    exp_err = 1'b0;
    rst = 1'b0;
    check("rst_active", active, 0);
    check("rst_ld_ready", ld_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_tile_cnt", tile_cnt, 0);
    check("rst_err", err, 0);
    check("rst_act_out", act_out, 0);
    check("rst_w_out", w_out, 0);
    check("rst_precision", precision, 0);
  endtask

  task automatic load_tile(input logic [N*ACT_WIDTH-1:0] a, input logic [N*W_MAX-1:0] w,
                           input logic [3:0] p);
    int n;
    n = 0;
    @(negedge clk);
    ld_valid = 1'b1;
    ld_act = a;
    ld_w = w;
    ld_prec = p;
    while (!ld_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check("ld_ready_timeout", 1, 0);
    @(posedge clk);
    exp_q.push_back({eff_prec(p), w, a});
    if (eff_prec(p) != p) exp_err = 1'b1;
    #1;
    ld_valid = 1'b0;
    @(negedge clk);
    check("ld_ready_drop", ld_ready, 0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy || in_burst) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) check("drain_timeout", 1, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_active(input logic level);
    int n;
    n = 0;
    while (active !== level && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("wait_active_timeout", 1, 0);
  endtask

  initial begin
    int cnt;
    rst = 1'b1;
    ld_valid = 1'b0;
    ld_act = '0;
    ld_w = '0;
    ld_prec = '0;
    do_reset();

    // Single tile, prec 4; first active cycle two cycles after the handshake.
    load_tile(32'h1234_ABCD, {8'h0A, 8'h03}, 4'd4);
    check("lat_first_not_yet", active, 0);
    @(negedge clk);
    check("lat_active", active, 1);
    check("lat_w_out_k0", w_out, 2'b01);
    drain();
    check("t1_tile_cnt", tile_cnt, exp_tiles);
    check("t1_err", err, 0);

    // Randomized back-to-back tiles with legal precisions.
    for (int i = 0; i < 20; i++)
      load_tile(32'($urandom), 16'($urandom), 4'($urandom_range(2, W_MAX)));
    drain();
    check("t3_tile_cnt", tile_cnt, exp_tiles);
    check("t3_err", err, exp_err);

    // Stray sa_done in STREAM and in IDLE must be ignored.
    load_tile(32'($urandom), 16'($urandom), 4'd8);
    wait_active(1'b1);
    done_stray = 1'b1;
    @(negedge clk);
    done_stray = 1'b0;
    drain();
    check("t6_stream_stray", tile_cnt, exp_tiles);
    done_stray = 1'b1;
    @(negedge clk);
    done_stray = 1'b0;
    repeat (2) @(negedge clk);
    check("t6_idle_stray", tile_cnt, exp_tiles);

    // Out-of-range precisions clamp to W_MAX and set the sticky error.
    load_tile(32'($urandom), 16'($urandom), 4'd1);
    check("t2_err_after_p1", err, 1);
    drain();
    load_tile(32'($urandom), 16'($urandom), 4'd9);
    drain();
    check("t2_err_sticky", err, 1);
    check("t2_tile_cnt", tile_cnt, exp_tiles);

    // No completion pulse: exactly 255 WAIT_DONE cycles, then abort.
    do_reset();
    resp_en = 1'b0;
    load_tile(32'($urandom), 16'($urandom), 4'd3);
    wait_active(1'b1);
    wait_active(1'b0);
    cnt = 0;
    while (busy && cnt < 1000) begin
      cnt++;
      @(negedge clk);
    end
    check("t4_wait_cycles", cnt, 255);
    check("t4_err", err, 1);
    check("t4_tile_cnt", tile_cnt, 0);
    resp_en = 1'b1;
    drain();

    // Reset during STREAM cycle 2, then a fresh tile streams from bit 0.
    load_tile(32'($urandom), 16'($urandom), 4'd8);
    load_tile(32'($urandom), 16'($urandom), 4'd8);
    wait_active(1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    exp_q.delete();
    exp_tiles = 0;
    exp_err = 1'b0;
    rst = 1'b0;
    check("t5_active", active, 0);
    check("t5_ld_ready", ld_ready, 1);
    check("t5_busy", busy, 0);
    check("t5_act_out", act_out, 0);
    check("t5_err", err, 0);
    repeat (3) @(negedge clk);
    check("t5_no_replay", active, 0);
    load_tile(32'($urandom), 16'($urandom), 4'($urandom_range(2, W_MAX)));
    drain();
    check("t5_tile_cnt", tile_cnt, exp_tiles);

    // Final random mix including illegal precisions.
    for (int i = 0; i < 12; i++)
      load_tile(32'($urandom), 16'($urandom), 4'($urandom_range(0, 15)));
    drain();
    check("mix_tile_cnt", tile_cnt, exp_tiles);
    check("mix_err", err, exp_err);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
